// File: rtl/tage_update_ctrl.sv
// TAGE update controller: turns one resolved-branch record into an update write to the
// provider table and, on a mispredict, allocation writes to all longer-history tables.
// Optional macro TAGE_UPD_STATS_EN adds saturating allocation success/failure counters.
module tage_update_ctrl #(
    parameter int NUM_TABLES = 4,
    parameter int IDX_SIZE   = 6,
    parameter int TAG_SIZE   = 8
) (
    input  logic                           clk,
    input  logic                           rst,

    // Handshake: a record transfers on a rising edge where IN_resValid && OUT_resReady;
    // the source must hold the record stable until then, ready is high only in IDLE.
    input  logic                           IN_resValid,
    output logic                           OUT_resReady,
    input  logic                           IN_resTaken,
    input  logic                           IN_resPredTaken,
    input  logic [2:0]                     IN_resProvider,
    input  logic                           IN_resProvTaken,
    input  logic                           IN_resAltTaken,
    input  logic [NUM_TABLES*IDX_SIZE-1:0] IN_resIdx,
    input  logic [NUM_TABLES*TAG_SIZE-1:0] IN_resTag,

    output logic [NUM_TABLES*IDX_SIZE-1:0] OUT_writeAddr,
    output logic [NUM_TABLES*TAG_SIZE-1:0] OUT_writeTag,
    output logic                           OUT_writeTaken,
    output logic [NUM_TABLES-1:0]          OUT_writeValid,
    output logic [NUM_TABLES-1:0]          OUT_writeUpdate,
    output logic [NUM_TABLES-1:0]          OUT_writeNew,
    output logic [NUM_TABLES-1:0]          OUT_writeUseful,
    input  logic [NUM_TABLES-1:0]          IN_writeAlloc,
    output logic                           OUT_anyAlloc,
`ifdef TAGE_UPD_STATS_EN
    output logic [15:0]                    OUT_allocCnt,
    output logic [15:0]                    OUT_allocFailCnt,
`endif
    // Debug view: {captured altTaken, state[1:0]}.
    output logic [2:0]                     OUT_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        UPD   = 2'd1,
        ALLOC = 2'd2
    } state_t;

    state_t state;
    state_t stateNext;

    logic                           takenReg;
    logic                           predTakenReg;
    logic [2:0]                     provReg;
    logic                           provTakenReg;
    logic                           altTakenReg;
    logic [NUM_TABLES*IDX_SIZE-1:0] idxReg;
    logic [NUM_TABLES*TAG_SIZE-1:0] tagReg;
    logic [NUM_TABLES-1:0]          allocMask;
    logic                           accept;

    assign accept = (state == IDLE) && IN_resValid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            takenReg     <= 1'b0;
            predTakenReg <= 1'b0;
            provReg      <= 3'd0;
            provTakenReg <= 1'b0;
            altTakenReg  <= 1'b0;
            idxReg       <= '0;
            tagReg       <= '0;
        end else begin
            state <= stateNext;
            if (accept) begin
                takenReg     <= IN_resTaken;
                predTakenReg <= IN_resPredTaken;
                // Out-of-range providers fall back to the base predictor.
                provReg      <= (int'(IN_resProvider) > NUM_TABLES) ? 3'd0 : IN_resProvider;
                provTakenReg <= IN_resProvTaken;
                altTakenReg  <= IN_resAltTaken;
                idxReg       <= IN_resIdx;
                tagReg       <= IN_resTag;
            end
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (IN_resValid) stateNext = UPD;
            UPD: begin
                if ((predTakenReg != takenReg) && (int'(provReg) < NUM_TABLES))
                    stateNext = ALLOC;
                else
                    stateNext = IDLE;
            end
            ALLOC:   stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Tables strictly longer than the provider (table k+1 > provider).
    always_comb begin
        allocMask = '0;
        for (int k = 0; k < NUM_TABLES; k++)
            allocMask[k] = (k >= int'(provReg));
    end

    always_comb begin
        OUT_resReady    = (state == IDLE);
        OUT_writeAddr   = '0;
        OUT_writeTag    = '0;
        OUT_writeTaken  = 1'b0;
        OUT_writeValid  = '0;
        OUT_writeUpdate = '0;
        OUT_writeNew    = '0;
        OUT_writeUseful = '0;
        OUT_anyAlloc    = 1'b0;
        case (state)
            UPD: begin
                OUT_writeAddr  = idxReg;
                OUT_writeTag   = tagReg;
                OUT_writeTaken = takenReg;
                for (int k = 0; k < NUM_TABLES; k++) begin
                    if (int'(provReg) == k + 1) begin
                        OUT_writeValid[k]  = 1'b1;
                        OUT_writeUpdate[k] = 1'b1;
                        OUT_writeUseful[k] = (provTakenReg == takenReg);
                    end
                end
            end
            ALLOC: begin
                OUT_writeAddr  = idxReg;
                OUT_writeTag   = tagReg;
                OUT_writeTaken = takenReg;
                OUT_writeValid = allocMask;
                OUT_writeNew   = allocMask;
                OUT_anyAlloc   = |(IN_writeAlloc & allocMask);
            end
            default: ;
        endcase
    end

    assign OUT_dbg = {altTakenReg, state};

`ifdef TAGE_UPD_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            OUT_allocCnt     <= 16'd0;
            OUT_allocFailCnt <= 16'd0;
        end else if (state == ALLOC) begin
            if (OUT_anyAlloc) begin
                if (OUT_allocCnt != 16'hFFFF) OUT_allocCnt <= OUT_allocCnt + 16'd1;
            end else begin
                if (OUT_allocFailCnt != 16'hFFFF) OUT_allocFailCnt <= OUT_allocFailCnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tage_update_ctrl.sv
// Directed bench for tage_update_ctrl: update, allocation, failure, reset and back-to-back cases.
// Stats counters are checked when TAGE_UPD_STATS_EN is defined.
module tb_tage_update_ctrl;

    localparam int NT = 4;
    localparam int IW = 6;
    localparam int TW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            resValid;
    logic            resReady;
    logic            resTaken;
    logic            resPredTaken;
    logic [2:0]      resProvider;
    logic            resProvTaken;
    logic            resAltTaken;
    logic [NT*IW-1:0] resIdx;
    logic [NT*TW-1:0] resTag;
    logic [NT*IW-1:0] writeAddr;
    logic [NT*TW-1:0] writeTag;
    logic            writeTaken;
    logic [NT-1:0]   writeValid;
    logic [NT-1:0]   writeUpdate;
    logic [NT-1:0]   writeNew;
    logic [NT-1:0]   writeUseful;
    logic [NT-1:0]   writeAlloc;
    logic            anyAlloc;
    logic [2:0]      dbg;
`ifdef TAGE_UPD_STATS_EN
    logic [15:0]     allocCnt;
    logic [15:0]     allocFailCnt;
`endif

    int total = 0;
    int bad   = 0;

    tage_update_ctrl #(.NUM_TABLES(NT), .IDX_SIZE(IW), .TAG_SIZE(TW)) dut (
        .clk             (clk),
        .rst             (rst),
        .IN_resValid     (resValid),
        .OUT_resReady    (resReady),
        .IN_resTaken     (resTaken),
        .IN_resPredTaken (resPredTaken),
        .IN_resProvider  (resProvider),
        .IN_resProvTaken (resProvTaken),
        .IN_resAltTaken  (resAltTaken),
        .IN_resIdx       (resIdx),
        .IN_resTag       (resTag),
        .OUT_writeAddr   (writeAddr),
        .OUT_writeTag    (writeTag),
        .OUT_writeTaken  (writeTaken),
        .OUT_writeValid  (writeValid),
        .OUT_writeUpdate (writeUpdate),
        .OUT_writeNew    (writeNew),
        .OUT_writeUseful (writeUseful),
        .IN_writeAlloc   (writeAlloc),
        .OUT_anyAlloc    (anyAlloc),
`ifdef TAGE_UPD_STATS_EN
        .OUT_allocCnt    (allocCnt),
        .OUT_allocFailCnt(allocFailCnt),
`endif
        .OUT_dbg         (dbg)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic [2:0] prov, input logic pred, input logic tkn,
                         input logic provT, input logic altT,
                         input logic [NT*IW-1:0] idx, input logic [NT*TW-1:0] tg);
        resValid     = 1'b1;
        resProvider  = prov;
        resPredTaken = pred;
        resTaken     = tkn;
        resProvTaken = provT;
        resAltTaken  = altT;
        resIdx       = idx;
        resTag       = tg;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ready"}, 32'(resReady), 32'd1);
        check({tag, "_valid"}, 32'(writeValid), 32'd0);
        check({tag, "_any"}, 32'(anyAlloc), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        resValid = 1'b0; resTaken = 1'b0; resPredTaken = 1'b0; resProvider = 3'd0;
        resProvTaken = 1'b0; resAltTaken = 1'b0; resIdx = '0; resTag = '0;
        writeAlloc = '0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        check_idle("rst");
        check("rst_state", 32'(dbg), 32'd0);
        check("rst_addr", 32'(writeAddr), 32'd0);
        check("rst_new", 32'(writeNew), 32'd0);
`ifdef TAGE_UPD_STATS_EN
        check("rst_cnt", {allocCnt, allocFailCnt}, 32'd0);
`endif

        // Correct provider 2: update only, back to IDLE two cycles after accept
        offer(3'd2, 1'b1, 1'b1, 1'b1, 1'b0, 24'hABCDEF, 32'h12345678);
        check("t1_ready_acc", 32'(resReady), 32'd1);
        step();
        resValid = 1'b0;
        check("t1_state", 32'(dbg), 32'd1);
        check("t1_ready", 32'(resReady), 32'd0);
        check("t1_valid", 32'(writeValid), 32'b0010);
        check("t1_update", 32'(writeUpdate), 32'b0010);
        check("t1_useful", 32'(writeUseful), 32'b0010);
        check("t1_new", 32'(writeNew), 32'd0);
        check("t1_taken", 32'(writeTaken), 32'd1);
        check("t1_addr", 32'(writeAddr), 32'hABCDEF);
        check("t1_tag", writeTag, 32'h12345678);
        step();
        check_idle("t1_end");

        // Mispredict from base: no update, allocate into all four tables
        offer(3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 24'h111111, 32'hCAFEF00D);
        step();
        resValid = 1'b0;
        check("t2_upd_valid", 32'(writeValid), 32'd0);
        check("t2_upd_update", 32'(writeUpdate), 32'd0);
        check("t2_dbg_alt", 32'(dbg), 32'b101);
        step();
        writeAlloc = 4'b0100;
        #1;
        check("t2_alloc_state", 32'(dbg[1:0]), 32'd2);
        check("t2_alloc_valid", 32'(writeValid), 32'b1111);
        check("t2_alloc_new", 32'(writeNew), 32'b1111);
        check("t2_alloc_update", 32'(writeUpdate), 32'd0);
        check("t2_alloc_taken", 32'(writeTaken), 32'd0);
        check("t2_alloc_tag", writeTag, 32'hCAFEF00D);
        check("t2_any", 32'(anyAlloc), 32'd1);
        step();
        writeAlloc = 4'b1111;
        #1;
        check_idle("t2_end");
        writeAlloc = '0;

        // Mispredict at longest table: update table 4, no allocation
        offer(3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 24'h222222, 32'h0);
        step();
        resValid = 1'b0;
        check("t3_valid", 32'(writeValid), 32'b1000);
        check("t3_update", 32'(writeUpdate), 32'b1000);
        check("t3_useful", 32'(writeUseful), 32'd0);
        step();
        check_idle("t3_end");
        check("t3_state", 32'(dbg[1:0]), 32'd0);

        // Allocation failure from provider 1
        offer(3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 24'h333333, 32'h55AA55AA);
        step();
        resValid = 1'b0;
        check("t4_upd_valid", 32'(writeValid), 32'b0001);
        check("t4_upd_useful", 32'(writeUseful), 32'd0);
        check("t4_upd_taken", 32'(writeTaken), 32'd1);
        step();
        check("t4_alloc_valid", 32'(writeValid), 32'b1110);
        check("t4_alloc_new", 32'(writeNew), 32'b1110);
        check("t4_any", 32'(anyAlloc), 32'd0);
        writeAlloc = 4'b0001;
        #1;
        check("t4_any_masked", 32'(anyAlloc), 32'd0);
        writeAlloc = '0;
        step();
        check_idle("t4_end");
`ifdef TAGE_UPD_STATS_EN
        check("t4_allocCnt", 32'(allocCnt), 32'd1);
        check("t4_failCnt", 32'(allocFailCnt), 32'd1);
`endif

        // Reset while in ALLOC drops the record
        offer(3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h444444, 32'h77777777);
        step();
        resValid = 1'b0;
        step();
        check("t5_alloc_valid", 32'(writeValid), 32'b1111);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle("t5_rst");
        check("t5_new", 32'(writeNew), 32'd0);
        check("t5_addr", 32'(writeAddr), 32'd0);
        step();
        check_idle("t5_after");

        // Out-of-range provider is treated as base: mispredict allocates everywhere
        offer(3'd6, 1'b1, 1'b0, 1'b1, 1'b0, 24'h555555, 32'h1);
        step();
        resValid = 1'b0;
        check("t6_upd_valid", 32'(writeValid), 32'd0);
        step();
        check("t6_alloc_new", 32'(writeNew), 32'b1111);
        step();
        check_idle("t6_end");

        // Back-to-back with valid held high
        offer(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 24'hA0A0A0, 32'hA5A5A5A5);
        step();
        offer(3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 24'hB0B0B0, 32'hB6B6B6B6);
        #1;
        check("t7_a_ready", 32'(resReady), 32'd0);
        check("t7_a_valid", 32'(writeValid), 32'b0100);
        check("t7_a_useful", 32'(writeUseful), 32'b0100);
        check("t7_a_addr", 32'(writeAddr), 32'hA0A0A0);
        step();
        check_idle("t7_gap");
        step();
        resValid = 1'b0;
        check("t7_b_valid", 32'(writeValid), 32'b0010);
        check("t7_b_useful", 32'(writeUseful), 32'd0);
        check("t7_b_addr", 32'(writeAddr), 32'hB0B0B0);
        step();
        check("t7_b_alloc", 32'(writeNew), 32'b1100);
        check("t7_b_alloc_valid", 32'(writeValid), 32'b1100);
        step();
        check_idle("t7_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
